fetch_pc_gen: RTL and testbench
===============================

# fetch_pc_gen

Fetch-stage program-counter sequencer that sits directly upstream of the branch target buffer. It owns the fetch PC and issues instruction-memory requests. It selects each next PC from sequential (+4), predicted-taken redirects, or mispredict flush redirects. The fetched PC and a valid flag are presented to IF and to the BTB lookup port (`Instr_PC_IN_IF`). Redirects that arrive while a fetch cannot advance are held until they can be applied.

## Interface
- `RESET_PC`, default 32'hBFC00000: PC of the first fetch after reset.
- `CNT_W`, default 16: width of the saturating statistics counters.

Ports:
- `CLK` in 1: clock, rising edge.
- `RESET` in 1: reset, asynchronous, active-low.
- `STALL` in 1: pipeline stall; no fetch is consumed while high.
- `take_Branch_IN` in 1: BTB redirect strobe (predicted taken, or mispredict correction).
- `take_Alt_PC_IN` in 32: redirect target; valid when `take_Branch_IN` or `FLUSH_IN` is high.
- `FLUSH_IN` in 1: mispredict flush strobe; its target is `take_Alt_PC_IN`.
- `imem_req` out 1: instruction-memory request.
- `imem_addr` out 32: request address; always equals the PC register.
- `imem_ack` in 1: memory accepts and returns the request this cycle; zero-wait is allowed.
- `Instr_PC_OUT_IF` out 32: PC of the instruction delivered to IF.
- `Instr_valid_OUT_IF` out 1: delivered-instruction valid.
- `redirect_count` out CNT_W: count of applied non-flush redirects, saturating.
- `flush_count` out CNT_W: count of applied flush redirects, saturating.

## Operation
- **States:** BOOT, FETCH, HOLD.
  - BOOT is entered on reset. After one clock it goes to FETCH, with PC = `RESET_PC`.
  - FETCH: `imem_req`=1. If `STALL`=1, go to HOLD.
  - HOLD: `imem_req`=0 and the PC is held. When `STALL`=0, return to FETCH.
- **Consume event:** state FETCH && `imem_ack` && !`STALL`. On a consume:
  - `Instr_PC_OUT_IF` <= PC.
  - `Instr_valid_OUT_IF` <= !(`FLUSH_IN` || pend_flush). An instruction fetched while a flush is resolving is squashed.
  - PC <= next_pc.
  - Pending state is cleared.
- **next_pc priority, highest first:**
  1. `FLUSH_IN` → `take_Alt_PC_IN`.
  2. pend_flush → pend_pc.
  3. `take_Branch_IN` → `take_Alt_PC_IN`.
  4. pend_branch → pend_pc.
  5. PC + 4, modulo 2^32.
- **Pending capture (non-consume cycles only):**
  - `FLUSH_IN` sets pend_flush=1 and pend_pc=`take_Alt_PC_IN`. This overwrites any pending branch.
  - `take_Branch_IN` without `FLUSH_IN` sets pend_branch=1 and pend_pc=target, but only when pend_flush=0. Otherwise it is dropped.
  - A later strobe of equal class overwrites the earlier one (newest wins).
- **Counters:** increment by 1 when a consume applies rule 1/2 (`flush_count`) or rule 3/4 (`redirect_count`). Each holds at 2^CNT_W−1.
- A flush strobe that arrives together with `take_Branch_IN` counts as a flush only.

## Timing
- **Reset values:**
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `Instr_PC_OUT_IF`=0, `Instr_valid_OUT_IF`=0.
  - Both counters 0; pending flags 0; state BOOT.
- **Startup:** the first `imem_req`=1 occurs in the first cycle after reset deasserts plus one clock (BOOT lasts exactly 1 cycle).
- **Delivery latency:** `Instr_valid_OUT_IF` is high in cycle N+1 for a consume in cycle N.
  - `Instr_valid_OUT_IF` is a one-cycle pulse per consume.
  - It is 0 in every cycle without a preceding consume.
- **Redirect latency:**
  - A strobe in a consume cycle N appears on `imem_addr` at N+1.
  - A strobe captured as pending appears on `imem_addr` one cycle after the next consume.
- **Memory handshake:** `imem_addr` is stable while `imem_req`=1 and `imem_ack`=0. `imem_ack` is ignored when `imem_req`=0.
- **Stall:** when `STALL` rises mid-request, the request is abandoned with no consume. It is reissued with the same address after `STALL` falls.
- **Reset mid-operation:** asynchronous clear. Pending redirects are lost, counters are cleared, and fetch restarts at `RESET_PC`.
- **Wrap:** PC 32'hFFFFFFFC + 4 → 32'h00000000, with no flag.

## Test plan
- **Reset and sequential fetch:** deassert `RESET`, then `imem_ack`=1 constantly. Expect:
  - `imem_addr` BFC00000, BFC00004, BFC00008 on consecutive cycles.
  - `Instr_PC_OUT_IF` following one cycle later with valid=1.
- **Predicted redirect:** `take_Branch_IN`=1 with target 0x00400100 in a consume cycle. Expect:
  - Next `imem_addr`=0x00400100.
  - `redirect_count`=1.
  - Delivered instruction valid=1.
- **Flush beats branch:** `FLUSH_IN` (target 0x1000) and `take_Branch_IN` (target 0x2000) in the same cycle. Expect:
  - `imem_addr`=0x1000.
  - That cycle's delivered valid=0.
  - `flush_count`=1, `redirect_count` unchanged.
- **Pending during wait:** `imem_ack`=0 for 3 cycles.
  - Pulse `take_Branch_IN` (target 0x3000) in cycle 1.
  - Pulse `FLUSH_IN` (target 0x4000) in cycle 2.
  - Then assert ack. Expect the next `imem_addr` after ack to be 0x4000, with the delivered instruction squashed.
- **Stall hold:** `STALL`=1 for 4 cycles mid-stream. Expect:
  - `imem_req`=0 and the address frozen during the stall.
  - No valid pulses during the stall.
  - Same address reissued when `STALL` falls.
- **Saturation and async reset:**
  - With `CNT_W`=2, apply 5 redirects. Expect `redirect_count`=3.
  - Drop `RESET` mid-cycle. Expect all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC sequencer: owns the fetch PC, issues instruction-memory requests
// and applies sequential, predicted and flush redirects (holding those that arrive mid-wait).
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             STALL,
    input  logic             take_Branch_IN,
    input  logic [31:0]      take_Alt_PC_IN,
    input  logic             FLUSH_IN,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    output logic [31:0]      Instr_PC_OUT_IF,
    output logic             Instr_valid_OUT_IF,
    output logic [CNT_W-1:0] redirect_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned PC_W = 32;
    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic            pend_flush;
    logic            pend_flush_nxt;
    logic            pend_branch;
    logic            pend_branch_nxt;
    logic [PC_W-1:0] pend_pc;
    logic [PC_W-1:0] pend_pc_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic            consume_c;
    logic            inc_flush_c;
    logic            inc_redir_c;

    // Next state, redirect selection and pending capture
    always_comb begin
        state_nxt       = state;
        pc_nxt          = imem_addr;
        pend_flush_nxt  = pend_flush;
        pend_branch_nxt = pend_branch;
        pend_pc_nxt     = pend_pc;
        inc_flush_c     = 1'b0;
        inc_redir_c     = 1'b0;
        consume_c       = 1'b0;

        case (state)
            ST_BOOT:  state_nxt = ST_FETCH;
            ST_FETCH: if (STALL)  state_nxt = ST_HOLD;
            ST_HOLD:  if (!STALL) state_nxt = ST_FETCH;
            default:  state_nxt = ST_BOOT;
        endcase

        consume_c = (state == ST_FETCH) && imem_ack && !STALL;

        if (consume_c) begin
            if (FLUSH_IN) begin
                pc_nxt      = take_Alt_PC_IN;
                inc_flush_c = 1'b1;
            end else if (pend_flush) begin
                pc_nxt      = pend_pc;
                inc_flush_c = 1'b1;
            end else if (take_Branch_IN) begin
                pc_nxt      = take_Alt_PC_IN;
                inc_redir_c = 1'b1;
            end else if (pend_branch) begin
                pc_nxt      = pend_pc;
                inc_redir_c = 1'b1;
            end else begin
                pc_nxt = imem_addr + PC_W'(4);
            end
            pend_flush_nxt  = 1'b0;
            pend_branch_nxt = 1'b0;
        end else if (FLUSH_IN) begin
            // A flush supersedes any held branch
            pend_flush_nxt  = 1'b1;
            pend_branch_nxt = 1'b0;
            pend_pc_nxt     = take_Alt_PC_IN;
        end else if (take_Branch_IN && !pend_flush) begin
            pend_branch_nxt = 1'b1;
            pend_pc_nxt     = take_Alt_PC_IN;
        end
    end

    // State, PC and pending registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= ST_BOOT;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            pend_flush  <= 1'b0;
            pend_branch <= 1'b0;
            pend_pc     <= '0;
        end else begin
            state       <= state_nxt;
            imem_req    <= (state_nxt == ST_FETCH);
            imem_addr   <= pc_nxt;
            pend_flush  <= pend_flush_nxt;
            pend_branch <= pend_branch_nxt;
            pend_pc     <= pend_pc_nxt;
        end
    end

    // Delivery to IF; instructions consumed while a flush resolves are squashed
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Instr_PC_OUT_IF    <= '0;
            Instr_valid_OUT_IF <= 1'b0;
        end else begin
            Instr_valid_OUT_IF <= consume_c && !(FLUSH_IN || pend_flush);
            if (consume_c) begin
                Instr_PC_OUT_IF <= imem_addr;
            end
        end
    end

    // Saturating redirect statistics
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            redirect_count <= '0;
            flush_count    <= '0;
        end else begin
            if (inc_redir_c && (redirect_count != CNT_MAX)) begin
                redirect_count <= redirect_count + CNT_W'(1);
            end
            if (inc_flush_c && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen; a second instance with 2-bit counters checks saturation.
module tb_fetch_pc_gen;

    logic        CLK;
    logic        RESET;
    logic        STALL;
    logic        take_Branch_IN;
    logic [31:0] take_Alt_PC_IN;
    logic        FLUSH_IN;
    logic        imem_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] Instr_PC_OUT_IF;
    logic        Instr_valid_OUT_IF;
    logic [15:0] redirect_count;
    logic [15:0] flush_count;
    logic        s_req;
    logic [31:0] s_addr;
    logic [31:0] s_ipc;
    logic        s_valid;
    logic [1:0]  s_redir;
    logic [1:0]  s_flush;

    int pass_cnt = 0;
    int total_cnt = 0;

    fetch_pc_gen #(.RESET_PC(32'hBFC00000), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .take_Branch_IN(take_Branch_IN),
        .take_Alt_PC_IN(take_Alt_PC_IN), .FLUSH_IN(FLUSH_IN), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .Instr_PC_OUT_IF(Instr_PC_OUT_IF),
        .Instr_valid_OUT_IF(Instr_valid_OUT_IF), .redirect_count(redirect_count),
        .flush_count(flush_count)
    );

    fetch_pc_gen #(.RESET_PC(32'hBFC00000), .CNT_W(2)) dut_sat (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .take_Branch_IN(take_Branch_IN),
        .take_Alt_PC_IN(take_Alt_PC_IN), .FLUSH_IN(FLUSH_IN), .imem_req(s_req),
        .imem_addr(s_addr), .imem_ack(imem_ack), .Instr_PC_OUT_IF(s_ipc),
        .Instr_valid_OUT_IF(s_valid), .redirect_count(s_redir), .flush_count(s_flush)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b0; STALL = 1'b0; take_Branch_IN = 1'b0; FLUSH_IN = 1'b0;
        take_Alt_PC_IN = 32'h0; imem_ack = 1'b0;
        step(); step();
        total_cnt++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", imem_req); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'hBFC00000) $display("FAIL rst_addr got %h exp bfc00000", imem_addr); else pass_cnt++;
        total_cnt++; if (Instr_PC_OUT_IF !== 32'h0) $display("FAIL rst_ipc got %h exp 0", Instr_PC_OUT_IF); else pass_cnt++;
        total_cnt++; if (Instr_valid_OUT_IF !== 1'b0) $display("FAIL rst_valid got %b exp 0", Instr_valid_OUT_IF); else pass_cnt++;
        total_cnt++; if (redirect_count !== 16'd0 || flush_count !== 16'd0) $display("FAIL rst_cnt got %0d/%0d exp 0/0", redirect_count, flush_count); else pass_cnt++;
    endtask

    task automatic test_sequential();
        RESET = 1'b1; imem_ack = 1'b1;
        step();
        total_cnt++; if (imem_req !== 1'b1) $display("FAIL boot_req got %b exp 1", imem_req); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'hBFC00000) $display("FAIL seq_addr0 got %h exp bfc00000", imem_addr); else pass_cnt++;
        total_cnt++; if (Instr_valid_OUT_IF !== 1'b0) $display("FAIL seq_valid0 got %b exp 0", Instr_valid_OUT_IF); else pass_cnt++;
        step();
        total_cnt++; if (imem_addr !== 32'hBFC00004) $display("FAIL seq_addr1 got %h exp bfc00004", imem_addr); else pass_cnt++;
        total_cnt++; if (Instr_PC_OUT_IF !== 32'hBFC00000 || Instr_valid_OUT_IF !== 1'b1) $display("FAIL seq_deliver1 got %h/%b exp bfc00000/1", Instr_PC_OUT_IF, Instr_valid_OUT_IF); else pass_cnt++;
        step();
        total_cnt++; if (imem_addr !== 32'hBFC00008) $display("FAIL seq_addr2 got %h exp bfc00008", imem_addr); else pass_cnt++;
        total_cnt++; if (Instr_PC_OUT_IF !== 32'hBFC00004 || Instr_valid_OUT_IF !== 1'b1) $display("FAIL seq_deliver2 got %h/%b exp bfc00004/1", Instr_PC_OUT_IF, Instr_valid_OUT_IF); else pass_cnt++;
    endtask

    task automatic test_branch();
        take_Branch_IN = 1'b1; take_Alt_PC_IN = 32'h00400100;
        step();
        take_Branch_IN = 1'b0;
        total_cnt++; if (imem_addr !== 32'h00400100) $display("FAIL br_addr got %h exp 00400100", imem_addr); else pass_cnt++;
        total_cnt++; if (Instr_PC_OUT_IF !== 32'hBFC00008 || Instr_valid_OUT_IF !== 1'b1) $display("FAIL br_deliver got %h/%b exp bfc00008/1", Instr_PC_OUT_IF, Instr_valid_OUT_IF); else pass_cnt++;
        total_cnt++; if (redirect_count !== 16'd1) $display("FAIL br_count got %0d exp 1", redirect_count); else pass_cnt++;
    endtask

    task automatic test_flush_beats_branch();
        FLUSH_IN = 1'b1; take_Branch_IN = 1'b1; take_Alt_PC_IN = 32'h00001000;
        step();
        FLUSH_IN = 1'b0; take_Branch_IN = 1'b0;
        total_cnt++; if (imem_addr !== 32'h00001000) $display("FAIL fl_addr got %h exp 00001000", imem_addr); else pass_cnt++;
        total_cnt++; if (Instr_valid_OUT_IF !== 1'b0) $display("FAIL fl_squash got %b exp 0", Instr_valid_OUT_IF); else pass_cnt++;
        total_cnt++; if (flush_count !== 16'd1 || redirect_count !== 16'd1) $display("FAIL fl_counts got %0d/%0d exp 1/1", flush_count, redirect_count); else pass_cnt++;
    endtask

    task automatic test_pending();
        imem_ack = 1'b0; take_Branch_IN = 1'b1; take_Alt_PC_IN = 32'h00003000;
        step();
        take_Branch_IN = 1'b0; FLUSH_IN = 1'b1; take_Alt_PC_IN = 32'h00004000;
        total_cnt++; if (imem_addr !== 32'h00001000 || Instr_valid_OUT_IF !== 1'b0) $display("FAIL pend_wait1 got %h/%b exp 00001000/0", imem_addr, Instr_valid_OUT_IF); else pass_cnt++;
        step();
        FLUSH_IN = 1'b0; take_Alt_PC_IN = 32'h0;
        step();
        total_cnt++; if (imem_addr !== 32'h00001000 || imem_req !== 1'b1) $display("FAIL pend_wait3 got %h/%b exp 00001000/1", imem_addr, imem_req); else pass_cnt++;
        imem_ack = 1'b1;
        step();
        total_cnt++; if (imem_addr !== 32'h00004000) $display("FAIL pend_flush_addr got %h exp 00004000", imem_addr); else pass_cnt++;
        total_cnt++; if (Instr_PC_OUT_IF !== 32'h00001000 || Instr_valid_OUT_IF !== 1'b0) $display("FAIL pend_squash got %h/%b exp 00001000/0", Instr_PC_OUT_IF, Instr_valid_OUT_IF); else pass_cnt++;
        total_cnt++; if (flush_count !== 16'd2 || redirect_count !== 16'd1) $display("FAIL pend_counts got %0d/%0d exp 2/1", flush_count, redirect_count); else pass_cnt++;
        step();
        total_cnt++; if (imem_addr !== 32'h00004004 || Instr_valid_OUT_IF !== 1'b1) $display("FAIL pend_cleared got %h/%b exp 00004004/1", imem_addr, Instr_valid_OUT_IF); else pass_cnt++;
        // Held branch applied on a later consume
        imem_ack = 1'b0; take_Branch_IN = 1'b1; take_Alt_PC_IN = 32'h00005000;
        step();
        take_Branch_IN = 1'b0; take_Alt_PC_IN = 32'h0; imem_ack = 1'b1;
        step();
        total_cnt++; if (imem_addr !== 32'h00005000 || redirect_count !== 16'd2) $display("FAIL pend_br got %h/%0d exp 00005000/2", imem_addr, redirect_count); else pass_cnt++;
        total_cnt++; if (Instr_PC_OUT_IF !== 32'h00004004 || Instr_valid_OUT_IF !== 1'b1) $display("FAIL pend_br_deliver got %h/%b exp 00004004/1", Instr_PC_OUT_IF, Instr_valid_OUT_IF); else pass_cnt++;
        step();
        total_cnt++; if (imem_addr !== 32'h00005004 || Instr_PC_OUT_IF !== 32'h00005000) $display("FAIL pend_br_next got %h/%h exp 00005004/00005000", imem_addr, Instr_PC_OUT_IF); else pass_cnt++;
    endtask

    task automatic test_stall();
        STALL = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total_cnt++; if (imem_req !== 1'b0 || imem_addr !== 32'h00005004 || Instr_valid_OUT_IF !== 1'b0)
                $display("FAIL stall_hold%0d got req=%b addr=%h v=%b exp 0/00005004/0", i, imem_req, imem_addr, Instr_valid_OUT_IF);
            else pass_cnt++;
        end
        STALL = 1'b0;
        step();
        total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h00005004 || Instr_valid_OUT_IF !== 1'b0) $display("FAIL stall_reissue got %b/%h/%b exp 1/00005004/0", imem_req, imem_addr, Instr_valid_OUT_IF); else pass_cnt++;
        step();
        total_cnt++; if (imem_addr !== 32'h00005008 || Instr_PC_OUT_IF !== 32'h00005004 || Instr_valid_OUT_IF !== 1'b1) $display("FAIL stall_resume got %h/%h/%b exp 00005008/00005004/1", imem_addr, Instr_PC_OUT_IF, Instr_valid_OUT_IF); else pass_cnt++;
    endtask

    task automatic test_wrap();
        take_Branch_IN = 1'b1; take_Alt_PC_IN = 32'hFFFFFFFC;
        step();
        take_Branch_IN = 1'b0; take_Alt_PC_IN = 32'h0;
        total_cnt++; if (imem_addr !== 32'hFFFFFFFC || redirect_count !== 16'd3) $display("FAIL wrap_pre got %h/%0d exp fffffffc/3", imem_addr, redirect_count); else pass_cnt++;
        step();
        total_cnt++; if (imem_addr !== 32'h00000000 || Instr_PC_OUT_IF !== 32'hFFFFFFFC) $display("FAIL wrap got %h/%h exp 00000000/fffffffc", imem_addr, Instr_PC_OUT_IF); else pass_cnt++;
    endtask

    task automatic test_saturation();
        total_cnt++; if (s_redir !== 2'd3) $display("FAIL sat_at3 got %0d exp 3", s_redir); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            take_Branch_IN = 1'b1; take_Alt_PC_IN = 32'h00010000 + 32'(i * 16);
            step();
        end
        take_Branch_IN = 1'b0; take_Alt_PC_IN = 32'h0;
        total_cnt++; if (redirect_count !== 16'd6) $display("FAIL sat_wide got %0d exp 6", redirect_count); else pass_cnt++;
        total_cnt++; if (s_redir !== 2'd3) $display("FAIL sat_hold got %0d exp 3", s_redir); else pass_cnt++;
        total_cnt++; if (s_flush !== 2'd2) $display("FAIL sat_flush got %0d exp 2", s_flush); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        imem_ack = 1'b0; take_Branch_IN = 1'b1; take_Alt_PC_IN = 32'h00007000;
        step();
        take_Branch_IN = 1'b0; take_Alt_PC_IN = 32'h0;
        #2 RESET = 1'b0;
        #1;
        total_cnt++; if (imem_req !== 1'b0 || imem_addr !== 32'hBFC00000) $display("FAIL arst_fetch got %b/%h exp 0/bfc00000", imem_req, imem_addr); else pass_cnt++;
        total_cnt++; if (Instr_PC_OUT_IF !== 32'h0 || Instr_valid_OUT_IF !== 1'b0) $display("FAIL arst_if got %h/%b exp 0/0", Instr_PC_OUT_IF, Instr_valid_OUT_IF); else pass_cnt++;
        total_cnt++; if (redirect_count !== 16'd0 || flush_count !== 16'd0 || s_redir !== 2'd0) $display("FAIL arst_cnt got %0d/%0d/%0d exp 0/0/0", redirect_count, flush_count, s_redir); else pass_cnt++;
        step();
        RESET = 1'b1; imem_ack = 1'b1;
        step();
        total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC00000) $display("FAIL arst_restart got %b/%h exp 1/bfc00000", imem_req, imem_addr); else pass_cnt++;
        step();
        total_cnt++; if (imem_addr !== 32'hBFC00004 || redirect_count !== 16'd0) $display("FAIL arst_pend_lost got %h/%0d exp bfc00004/0", imem_addr, redirect_count); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_flush_beats_branch();
        test_pending();
        test_stall();
        test_wrap();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
